// File: rtl/axis_ft245_tx_arb.sv
// Packet-level round-robin arbiter feeding the FT245 bridge transmit stream.
// Ports: clk/rst, s_axis_* (N byte-wide sources), m_axis_* (to bridge),
// grant_id (current/most recent grantee), busy (grant held).
// Optional macro FT245_ARB_HDR_EN: emits {4'hA, grant_id} header per grant.
module axis_ft245_tx_arb #(
    parameter int N         = 4,
    parameter int MAX_BURST = 512,
    parameter int CNT_W     = 16,
    localparam int GW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*8-1:0]   s_axis_tdata,
    input  logic [N-1:0]     s_axis_tvalid,
    input  logic [N-1:0]     s_axis_tlast,
    output logic [N-1:0]     s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [GW-1:0]    grant_id,
    output logic             busy
);

`ifdef FT245_ARB_HDR_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
    localparam state_t FIRST = HDR;
`else
    typedef enum logic [0:0] {IDLE, DATA} state_t;
    localparam state_t FIRST = DATA;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT =
        CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    state_t          state, state_nx;
    logic [GW-1:0]   rr_ptr, rr_nx, grant_nx, pick;
    logic [CNT_W-1:0] burst_cnt, cnt_nx;
    logic            found, burst_hit;
    int              idx;

    // First requester after the previous grantee wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && s_axis_tvalid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    assign burst_hit = (MAX_BURST != 0) && (burst_cnt == LAST_CNT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= GW'(N - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            grant_id  <= grant_nx;
            rr_ptr    <= rr_nx;
            burst_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant_id;
        rr_nx         = rr_ptr;
        cnt_nx        = burst_cnt;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_nx = pick;
                    rr_nx    = pick;
                    cnt_nx   = '0;
                    state_nx = FIRST;
                end
            end
`ifdef FT245_ARB_HDR_EN
            HDR: begin
                m_axis_tdata  = {4'hA, 4'(grant_id)};
                m_axis_tvalid = 1'b1;
                if (m_axis_tready)
                    state_nx = DATA;
            end
`endif
            DATA: begin
                m_axis_tdata  = s_axis_tdata[8*grant_id +: 8];
                m_axis_tvalid = s_axis_tvalid[grant_id];
                s_axis_tready[grant_id] = m_axis_tready;
                if (m_axis_tvalid && m_axis_tready) begin
                    cnt_nx = burst_cnt + 1'b1;
                    // tlast and burst limit on one beat is one release
                    if (s_axis_tlast[grant_id] || burst_hit)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
